// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the async SRAM sequencing controller.
// State encoding, idle strobe pattern and default geometry/timing.
package sram_controller_pkg;

    localparam int unsigned DEF_ADDR_W  = 18;
    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_RD_WAIT = 2;
    localparam int unsigned DEF_WR_WAIT = 2;

    // {csx, oex, wex} with every strobe released
    localparam logic [2:0] STROBE_IDLE = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_ACCESS = 3'd1,
        ST_RD_TURN   = 3'd2,
        ST_WR_SETUP  = 3'd3,
        ST_WR_PULSE  = 3'd4,
        ST_WR_HOLD   = 3'd5
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sram_controller_inout.sv
// Single-bit bidirectional pad buffer: drives the pin when dir=1, always returns the pin value.
module sram_controller_inout (
    input  logic i_dir,
    input  logic i_data_w,
    output logic o_data_r,
    inout  wire  io_pad
);

    assign io_pad   = i_dir ? i_data_w : 1'bz;
    assign o_data_r = io_pad;

endmodule

// File: rtl/sram_controller.sv
// Single-word read/write sequencer for an external asynchronous SRAM,
// with a released-bus turnaround cycle after every read.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned RD_WAIT = DEF_RD_WAIT,
    parameter int unsigned WR_WAIT = DEF_WR_WAIT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_ready,
    output logic              o_ack,
    output logic [DATA_W-1:0] o_rdata,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_sram_csx,
    output logic              o_sram_oex,
    output logic              o_sram_wex,
    inout  wire  [DATA_W-1:0] io_sram_data
);

    localparam int unsigned CNT_W = $clog2(max_u(RD_WAIT, WR_WAIT) + 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_cnt_zero;

    logic              r_ready;
    logic              r_ack;
    logic              r_csx;
    logic              r_oex;
    logic              r_wex;
    logic              r_dir;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_data_r;

    logic [2:0]        w_strobe_next;
    logic              w_dir_next;
    logic              w_ack_next;
    logic              w_ready_next;

    assign w_cnt_zero = (r_cnt == '0);

    // State, wait counter, request latches and registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_ack   <= 1'b0;
            r_csx   <= STROBE_IDLE[2];
            r_oex   <= STROBE_IDLE[1];
            r_wex   <= STROBE_IDLE[0];
            r_dir   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state                 <= w_state_next;
            r_cnt                   <= w_cnt_next;
            r_ready                 <= w_ready_next;
            r_ack                   <= w_ack_next;
            {r_csx, r_oex, r_wex}   <= w_strobe_next;
            r_dir                   <= w_dir_next;
            if (r_state == ST_IDLE && i_req) begin
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
            end
            if (r_state == ST_RD_ACCESS && w_cnt_zero) begin
                r_rdata <= w_data_r;
            end
        end
    end

    // Next-state and counter reload on entry to each wait state
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_req) begin
                    w_state_next = i_we ? ST_WR_SETUP : ST_RD_ACCESS;
                    w_cnt_next   = CNT_W'(RD_WAIT - 1);
                end
            end
            ST_RD_ACCESS: begin
                if (w_cnt_zero) begin
                    w_state_next = ST_RD_TURN;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ST_RD_TURN: w_state_next = ST_IDLE;
            ST_WR_SETUP: begin
                w_state_next = ST_WR_PULSE;
                w_cnt_next   = CNT_W'(WR_WAIT - 1);
            end
            ST_WR_PULSE: begin
                if (w_cnt_zero) begin
                    w_state_next = ST_WR_HOLD;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ST_WR_HOLD: w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Output decode of the upcoming state; oex low and dir high are never paired
    always_comb begin
        w_strobe_next = STROBE_IDLE;
        w_dir_next    = 1'b0;
        w_ack_next    = 1'b0;
        w_ready_next  = 1'b0;
        case (w_state_next)
            ST_IDLE:      w_ready_next = 1'b1;
            ST_RD_ACCESS: w_strobe_next = 3'b001;
            ST_RD_TURN:   w_ack_next = 1'b1;
            ST_WR_SETUP: begin
                w_strobe_next = 3'b011;
                w_dir_next    = 1'b1;
            end
            ST_WR_PULSE: begin
                w_strobe_next = 3'b010;
                w_dir_next    = 1'b1;
            end
            ST_WR_HOLD: begin
                w_strobe_next = 3'b011;
                w_dir_next    = 1'b1;
                w_ack_next    = 1'b1;
            end
            default: w_strobe_next = STROBE_IDLE;
        endcase
    end

    for (genvar i = 0; i < int'(DATA_W); i++) begin : g_io
        sram_controller_inout u_io (
            .i_dir    (r_dir),
            .i_data_w (r_wdata[i]),
            .o_data_r (w_data_r[i]),
            .io_pad   (io_sram_data[i])
        );
    end

    assign o_ready     = r_ready;
    assign o_ack       = r_ack;
    assign o_rdata     = r_rdata;
    assign o_sram_addr = r_addr;
    assign o_sram_csx  = r_csx;
    assign o_sram_oex  = r_oex;
    assign o_sram_wex  = r_wex;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (waits 2/2 and 1/1), behavioural SRAM,
// reference memory and per-instance scoreboard of expected acks.
module tb_sram_controller;

    typedef struct {
        bit          is_rd;
        logic [15:0] data;
        int unsigned due;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req [2];
    logic        we [2];
    logic [17:0] addr [2];
    logic [15:0] wdata [2];
    logic        ready [2];
    logic        ack [2];
    logic [15:0] rdata [2];
    logic [17:0] sram_addr [2];
    logic        csx [2];
    logic        oex [2];
    logic        wex [2];
    logic        dir [2];
    wire  [15:0] bus0;
    wire  [15:0] bus1;

    logic [15:0] sram0 [0:262143];
    logic [15:0] sram1 [0:262143];
    logic [15:0] rd0, rd1;
    logic [15:0] refm [logic [18:0]];
    sb_t         q0 [$];
    sb_t         q1 [$];

    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          wex_run [2];
    logic [15:0] cur_wd [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_controller #(.ADDR_W(18), .DATA_W(16), .RD_WAIT(2), .WR_WAIT(2)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req[0]), .i_we(we[0]), .i_addr(addr[0]),
        .i_wdata(wdata[0]), .o_ready(ready[0]), .o_ack(ack[0]), .o_rdata(rdata[0]),
        .o_sram_addr(sram_addr[0]), .o_sram_csx(csx[0]), .o_sram_oex(oex[0]),
        .o_sram_wex(wex[0]), .io_sram_data(bus0));

    sram_controller #(.ADDR_W(18), .DATA_W(16), .RD_WAIT(1), .WR_WAIT(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req[1]), .i_we(we[1]), .i_addr(addr[1]),
        .i_wdata(wdata[1]), .o_ready(ready[1]), .o_ack(ack[1]), .o_rdata(rdata[1]),
        .o_sram_addr(sram_addr[1]), .o_sram_csx(csx[1]), .o_sram_oex(oex[1]),
        .o_sram_wex(wex[1]), .io_sram_data(bus1));

    assign dir[0] = u_dut0.r_dir;
    assign dir[1] = u_dut1.r_dir;

    // Asynchronous SRAM: drives pins while selected and output-enabled
    always_comb rd0 = sram0[sram_addr[0]];
    always_comb rd1 = sram1[sram_addr[1]];
    assign bus0 = (!csx[0] && !oex[0]) ? rd0 : 16'bz;
    assign bus1 = (!csx[1] && !oex[1]) ? rd1 : 16'bz;

    function automatic int unsigned rdw(input int g);
        return (g == 0) ? 2 : 1;
    endfunction

    function automatic int unsigned wrw(input int g);
        return (g == 0) ? 2 : 1;
    endfunction

    function automatic logic [15:0] ref_get(input int g, input logic [17:0] a);
        logic [18:0] k;
        k = {g[0], a};
        return refm.exists(k) ? refm[k] : 16'h0000;
    endfunction

    function automatic int qsize(input int g);
        return (g == 0) ? q0.size() : q1.size();
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle protocol checks, ack scoreboard and acceptance bookkeeping
    task automatic mon(input int g, input logic [15:0] bus);
        sb_t e;
        if (!rst_n) begin
            wex_run[g] = 0;
            return;
        end
        chk("oex_dir_overlap", 32'(!oex[g] && dir[g]), 32'd0);
        if (!wex[g]) begin
            wex_run[g]++;
            chk("write_pins", 32'(bus), 32'(cur_wd[g]));
        end else if (wex_run[g] != 0) begin
            chk("wex_width", 32'(wex_run[g]), 32'(wrw(g)));
            wex_run[g] = 0;
        end
        if (ack[g]) begin
            chk("ack_has_req", 32'(qsize(g) != 0), 32'd1);
            if (qsize(g) != 0) begin
                e = (g == 0) ? q0.pop_front() : q1.pop_front();
                chk("ack_cycle", cyc, e.due);
                if (e.is_rd) chk("rdata", 32'(rdata[g]), 32'(e.data));
            end
        end
        if (req[g] && ready[g]) begin
            e.is_rd = !we[g];
            e.due   = cyc + 1 + (we[g] ? wrw(g) + 1 : rdw(g));
            e.data  = we[g] ? wdata[g] : ref_get(g, addr[g]);
            if (we[g]) begin
                refm[{g[0], addr[g]}] = wdata[g];
                cur_wd[g] = wdata[g];
            end
            if (g == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) begin
            sram0[i] = 16'h0000;
            sram1[i] = 16'h0000;
        end
        wex_run[0] = 0;
        wex_run[1] = 0;
        cur_wd[0]  = 16'h0000;
        cur_wd[1]  = 16'h0000;
        forever begin
            @(negedge clk);
            if (!csx[0] && !wex[0]) sram0[sram_addr[0]] = bus0;
            if (!csx[1] && !wex[1]) sram1[sram_addr[1]] = bus1;
            mon(0, bus0);
            mon(1, bus1);
        end
    end

    // Present a request and hold it until the cycle it is accepted; req stays high
    task automatic issue(input int g, input logic w, input logic [17:0] a,
                         input logic [15:0] d, output int unsigned acc);
        bit ok;
        ok  = 1'b0;
        acc = 0;
        req[g] = 1'b1; we[g] = w; addr[g] = a; wdata[g] = d;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready[g]) begin
                ok  = 1'b1;
                acc = cyc;
                break;
            end
        end
        chk("accepted", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int g);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (qsize(g) == 0 && ready[g]) break;
        end
        chk("drained", 32'(qsize(g)), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned a, b, c, d;
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            req[g] = 1'b0; we[g] = 1'b0; addr[g] = '0; wdata[g] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_ready", 32'(ready[g]), 32'd1);
            chk("rst_ack", 32'(ack[g]), 32'd0);
            chk("rst_strobes", 32'({csx[g], oex[g], wex[g]}), 32'b111);
            chk("rst_addr", 32'(sram_addr[g]), 32'd0);
            chk("rst_rdata", 32'(rdata[g]), 32'd0);
            chk("rst_dir", 32'(dir[g]), 32'd0);
        end
        @(posedge clk);
        #1;

        // Write then read back the same word
        issue(0, 1'b1, 18'h00010, 16'hBEEF, a);
        issue(0, 1'b0, 18'h00010, 16'h0000, b);
        req[0] = 1'b0;
        wait_done(0);
        chk("wr_rd_interval", b - a, wrw(0) + 3);
        chk("sram_beef", 32'(sram0[18'h00010]), 32'h0000BEEF);
        chk("rdata_held", 32'(rdata[0]), 32'h0000BEEF);

        // Back-to-back write/read/write/read with req held high
        issue(0, 1'b1, 18'h00020, 16'h1234, a);
        issue(0, 1'b0, 18'h00020, 16'h0000, b);
        issue(0, 1'b1, 18'h00021, 16'h5678, c);
        issue(0, 1'b0, 18'h00021, 16'h0000, d);
        req[0] = 1'b0;
        wait_done(0);
        chk("b2b_wr_rd", b - a, wrw(0) + 3);
        chk("b2b_rd_wr", c - b, rdw(0) + 2);
        chk("b2b_wr_rd2", d - c, wrw(0) + 3);

        // A different request presented while busy must not be taken
        issue(0, 1'b1, 18'h00031, 16'h1111, a);
        addr[0] = 18'h00030; wdata[0] = 16'hDEAD;
        repeat (2) @(posedge clk);
        #1 req[0] = 1'b0;
        wait_done(0);
        issue(0, 1'b0, 18'h00030, 16'h0000, a);
        issue(0, 1'b0, 18'h00031, 16'h0000, b);
        req[0] = 1'b0;
        wait_done(0);
        chk("busy_ignored", 32'(sram0[18'h00030]), 32'h00000000);
        chk("rdata_1111", 32'(rdata[0]), 32'h00001111);

        // Top of the address space
        issue(0, 1'b1, 18'h3FFFF, 16'hA5C3, a);
        issue(0, 1'b0, 18'h3FFFF, 16'h0000, b);
        req[0] = 1'b0;
        chk("top_addr_pins", 32'(sram_addr[0]), 32'h0003FFFF);
        chk("rd_strobes", 32'({csx[0], oex[0], wex[0]}), 32'b001);
        wait_done(0);
        chk("sram_top", 32'(sram0[18'h3FFFF]), 32'h0000A5C3);

        // Reset in the middle of a write pulse
        issue(0, 1'b1, 18'h00777, 16'hCAFE, a);
        req[0] = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (!wex[0]) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("wex_seen", 32'(seen), 32'd1);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("mid_rst_strobes", 32'({csx[0], oex[0], wex[0]}), 32'b111);
            chk("mid_rst_dir", 32'(dir[0]), 32'd0);
            chk("mid_rst_ack", 32'(ack[0]), 32'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        q0.delete();
        repeat (8) @(negedge clk);
        chk("post_rst_ready", 32'(ready[0]), 32'd1);
        @(posedge clk);
        #1;

        // Minimum waits: 4-cycle writes, 3-cycle reads, single-cycle wex pulse
        issue(1, 1'b1, 18'h00040, 16'h0F0F, a);
        issue(1, 1'b0, 18'h00040, 16'h0000, b);
        issue(1, 1'b1, 18'h3FFFF, 16'h7E81, c);
        issue(1, 1'b0, 18'h3FFFF, 16'h0000, d);
        req[1] = 1'b0;
        wait_done(1);
        chk("w1_wr_rd", b - a, 32'd4);
        chk("w1_rd_wr", c - b, 32'd3);
        chk("w1_wr_rd2", d - c, 32'd4);
        chk("w1_sram_top", 32'(sram1[18'h3FFFF]), 32'h00007E81);
        chk("w1_rdata", 32'(rdata[1]), 32'h00007E81);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Sequencing controller for the external asynchronous 16-bit SRAM on the Hack FPGA board. It accepts single-word read/write requests from the CPU/memory-map side, drives address and active-low strobes, and controls direction (`dir`) and data (`dataW`/`dataR`) of one `InOut` buffer per data pin. Bus turnaround is enforced so FPGA and SRAM never drive the data pins simultaneously.

## Interface
Parameters:
- `ADDR_W`, 18, SRAM address width
- `DATA_W`, 16, data width; number of `InOut` instances
- `RD_WAIT`, 2, cycles strobes held before read data is sampled (≥1)
- `WR_WAIT`, 2, cycles `sram_wex` held low (≥1)

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: system clock, all state on rising edge
- `rst_n` in 1: synchronous active-low reset
- `req` in 1: request strobe, sampled only when `ready`=1
- `we` in 1: 1=write, 0=read, qualified by `req`
- `addr` in ADDR_W: word address
- `wdata` in DATA_W: write data
- `ready` out 1: controller idle, will accept `req` this cycle
- `ack` out 1: one-cycle completion pulse
- `rdata` out DATA_W: read data, valid from `ack` until next read completes
- `sram_addr` out ADDR_W: address pins
- `sram_csx`, `sram_oex`, `sram_wex` out 1: active-low chip select, output enable, write enable
- `SRAM_DATA` inout DATA_W: data pins, via `InOut`

## Operation
- States: IDLE, RD_ACCESS, RD_TURN, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE: `ready`=1, strobes high, `dir`=0. On `req`=1: latch `addr`→`sram_addr`, `wdata`→write register; `we`=0→RD_ACCESS, `we`=1→WR_SETUP.
- RD_ACCESS: `csx`=0, `oex`=0, `dir`=0, for RD_WAIT cycles (counter). On last cycle's edge: capture `dataR` bus into `rdata`, →RD_TURN.
- RD_TURN: 1 cycle, strobes high, `dir`=0, `ack`=1; →IDLE. Guarantees one released-bus cycle before any subsequent write drive.
- WR_SETUP: 1 cycle, `csx`=0, `oex`=1, `wex`=1, `dir`=1, `dataW`=write register; →WR_PULSE.
- WR_PULSE: WR_WAIT cycles, as WR_SETUP but `wex`=0; →WR_HOLD.
- WR_HOLD: 1 cycle, `wex`=1, `csx`=0, `dir`=1 (data held past `wex` rise), `ack`=1; →IDLE.
- `req` when `ready`=0 is ignored; requester holds `req` until accepted. `addr`/`we`/`wdata` need only be valid in the accepting cycle.
- `oex`=0 and `dir`=1 never coexist in any state.
- Wait counter width `$clog2(max(RD_WAIT,WR_WAIT)+1)`; reloaded on entry to each wait state, no wrap.

## Timing
- All outputs registered or decoded from registered state; `ready` = (state==IDLE).
- Reset values: state IDLE, `ready`=1, `ack`=0, `csx`=`oex`=`wex`=1, `dir`=0, `sram_addr`=0, `rdata`=0.
- Read: `req` accepted at edge E0; `ack` high in cycle after edge E0+RD_WAIT; `ready` again after E0+RD_WAIT+1. Read issue interval RD_WAIT+2.
- Write: `ack` high in cycle after edge E0+WR_WAIT+1; issue interval WR_WAIT+3.
- `req` accepted in the same cycle `ack` ends (IDLE) is legal; back-to-back operations have no idle gap beyond the above.
- `rst_n` low mid-operation: at next edge, state IDLE, bus released (`dir`=0), strobes high, no `ack`; latched request discarded.

## Structure
- Shared package: state enum encoding, strobe-inactive constant (3'b111 for csx/oex/wex), default wait parameters.
- One generate loop of `InOut` instances (common `dir`); no other sub-module. FSM and counter in one always block.

## Test plan
- Reset: hold `rst_n`=0 3 cycles mid-write → strobes 3'b111, `dir`=0, `ack` never asserts, `ready`=1 after release.
- Write `addr`=18'h00010, `wdata`=16'hBEEF, then read same → SRAM model holds 16'hBEEF; `rdata`=16'hBEEF with `ack` exactly RD_WAIT+1 cycles after acceptance.
- Back-to-back write→read→write with `req` held high → no cycle where `oex`=0 and `dir`=1; one RD_TURN cycle precedes second write's drive.
- `req` asserted during busy states → ignored; exactly one `ack` per accepted request.
- RD_WAIT=1, WR_WAIT=1 → read interval 3 cycles, write interval 4 cycles; `wex` low exactly 1 cycle.
- Address 18'h3FFFF read/write → full-width address on pins, correct data.
